// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO block: register byte offsets and the
// 3-bit register index decoded from PADDR[4:2].
package gpio_pkg;

  localparam logic [4:0] MODE_OFS = 5'h00;
  localparam logic [4:0] ODR_OFS  = 5'h04;
  localparam logic [4:0] IDR_OFS  = 5'h08;
  localparam logic [4:0] IER_OFS  = 5'h0C;
  localparam logic [4:0] RISE_OFS = 5'h10;
  localparam logic [4:0] FALL_OFS = 5'h14;
  localparam logic [4:0] ISR_OFS  = 5'h18;

  typedef enum logic [2:0] {
    REG_MODE = MODE_OFS[4:2],
    REG_ODR  = ODR_OFS[4:2],
    REG_IDR  = IDR_OFS[4:2],
    REG_IER  = IER_OFS[4:2],
    REG_RISE = RISE_OFS[4:2],
    REG_FALL = FALL_OFS[4:2],
    REG_ISR  = ISR_OFS[4:2],
    REG_RSVD = 3'd7
  } reg_idx_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser plus one history flop per GPIO bit, with edge detect.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   pin       asynchronous pad inputs
//   mode      per-bit direction (1=output); output bits never report edges
//   sync      synchronised input (last synchroniser stage)
//   rise/fall single-cycle edge strobes derived from sync vs. history
module gpio_sync_edge #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic [WIDTH-1:0] mode,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stages [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stages[i] <= '0;
      prev <= '0;
    end else begin
      stages[0] <= pin;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stages[i] <= stages[i-1];
      prev <= stages[SYNC_STAGES-1];
    end
  end

  assign sync = stages[SYNC_STAGES-1];
  // prev follows sync one cycle later, so each strobe lasts exactly one cycle.
  assign rise = sync & ~prev & ~mode;
  assign fall = ~sync & prev & ~mode;

endmodule

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO peripheral with per-bit direction, output data, synchronised
// input readback and sticky W1C edge interrupt status.
// Ports:
//   PCLK, PRESET                clock, asynchronous active-high reset
//   PADDR/PWDATA/PWRITE/PENABLE/PSEL  APB3 request
//   PRDATA/PREADY               APB3 response (one wait state)
//   inPort                      asynchronous pad inputs
//   outPort/outEnable           pad output data and drive enable
//   irq                         level interrupt = |(ISR & IER)
module apb_gpio_irq
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [4:0]       PADDR,
  input  logic [31:0]      PWDATA,
  input  logic             PWRITE,
  input  logic             PENABLE,
  input  logic             PSEL,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  input  logic [WIDTH-1:0] inPort,
  output logic [WIDTH-1:0] outPort,
  output logic [WIDTH-1:0] outEnable,
  output logic             irq
);

  logic [WIDTH-1:0] mode_q, odr_q, ier_q, rise_en_q, fall_en_q, isr_q;
  logic [WIDTH-1:0] sync, rise, fall, wdata, w1c, idr;
  logic [31:0]      rdata_next;
  reg_idx_e         idx;
  logic             access, wr;
  logic             unused_bits;

  gpio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk (PCLK),
    .rst (PRESET),
    .pin (inPort),
    .mode(mode_q),
    .sync(sync),
    .rise(rise),
    .fall(fall)
  );

  assign idx    = reg_idx_e'(PADDR[4:2]);
  // Gating on ~PREADY makes the access fire once even if the master holds
  // PSEL/PENABLE through the ready cycle.
  assign access = PSEL & PENABLE & ~PREADY;
  assign wr     = access & PWRITE;
  assign wdata  = PWDATA[WIDTH-1:0];
  assign w1c    = (wr && idx == REG_ISR) ? wdata : '0;
  assign idr    = sync & ~mode_q;

  assign unused_bits = ^{PADDR[1:0], PWDATA};

  always_comb begin
    rdata_next = '0;
    case (idx)
      REG_MODE: rdata_next[WIDTH-1:0] = mode_q;
      REG_ODR:  rdata_next[WIDTH-1:0] = odr_q;
      REG_IDR:  rdata_next[WIDTH-1:0] = idr;
      REG_IER:  rdata_next[WIDTH-1:0] = ier_q;
      REG_RISE: rdata_next[WIDTH-1:0] = rise_en_q;
      REG_FALL: rdata_next[WIDTH-1:0] = fall_en_q;
      REG_ISR:  rdata_next[WIDTH-1:0] = isr_q;
      default:  rdata_next = '0;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      mode_q    <= '0;
      odr_q     <= '0;
      ier_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      isr_q     <= '0;
    end else begin
      PREADY <= access;
      if (access && !PWRITE) PRDATA <= rdata_next;
      if (wr) begin
        case (idx)
          REG_MODE: mode_q    <= wdata;
          REG_ODR:  odr_q     <= wdata;
          REG_IER:  ier_q     <= wdata;
          REG_RISE: rise_en_q <= wdata;
          REG_FALL: fall_en_q <= wdata;
          default:  ;
        endcase
      end
      // Set terms are OR-ed after the clear, so a coincident edge wins.
      isr_q <= (isr_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end
  end

  assign outEnable = mode_q;
  assign outPort   = odr_q & mode_q;
  assign irq       = |(isr_q & ier_q);

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Directed self-checking bench for apb_gpio_irq (WIDTH=8, SYNC_STAGES=2).
module tb_apb_gpio_irq;

  localparam int unsigned WIDTH = 8;

  logic             PCLK = 1'b0;
  logic             PRESET = 1'b1;
  logic [4:0]       PADDR = '0;
  logic [31:0]      PWDATA = '0;
  logic             PWRITE = 1'b0;
  logic             PENABLE = 1'b0;
  logic             PSEL = 1'b0;
  logic [31:0]      PRDATA;
  logic             PREADY;
  logic [WIDTH-1:0] inPort = '0;
  logic [WIDTH-1:0] outPort;
  logic [WIDTH-1:0] outEnable;
  logic             irq;

  int checks = 0;
  int errors = 0;

  apb_gpio_irq #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .inPort   (inPort),
    .outPort  (outPort),
    .outEnable(outEnable),
    .irq      (irq)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Setup phase at the first edge, access at the second; PREADY must be low
  // after the first edge and high after the second.
  task automatic apb_xfer(input logic [4:0] addr, input logic write,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    PSEL = 1'b1; PWRITE = write; PADDR = addr; PWDATA = wdata; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    checks++;
    if (PREADY !== 1'b0) begin
      errors++;
      $display("FAIL pready_wait addr=%h: PREADY=%b, expected 0", addr, PREADY);
    end
    @(posedge PCLK); #1;
    checks++;
    if (PREADY !== 1'b1) begin
      errors++;
      $display("FAIL pready_pulse addr=%h: PREADY=%b, expected 1", addr, PREADY);
    end
    rdata = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_write(input logic [4:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    apb_xfer(addr, 1'b1, data, dummy);
  endtask

  task automatic apb_read(input logic [4:0] addr, output logic [31:0] data);
    apb_xfer(addr, 1'b0, 32'h0, data);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #2;
    checks++;
    if ({PRDATA, PREADY, outPort, outEnable, irq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: PRDATA=%h PREADY=%b outPort=%h outEnable=%h irq=%b, expected all 0",
               PRDATA, PREADY, outPort, outEnable, irq);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apb_read(5'(i * 4), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_read ofs=%h: PRDATA=%h, expected 00000000", 5'(i * 4), d);
      end
      @(posedge PCLK); #1;
      checks++;
      if (PREADY !== 1'b0) begin
        errors++;
        $display("FAIL pready_drop ofs=%h: PREADY=%b, expected 0", 5'(i * 4), PREADY);
      end
    end
    checks++;
    if (outEnable !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: outEnable=%h irq=%b, expected 00 0", outEnable, irq);
    end
  endtask

  task automatic test_mode_odr;
    logic [31:0] d;
    inPort = 8'h3C;
    apb_write(5'h00, 32'hFFFF_FF0F);
    apb_write(5'h04, 32'h0000_00FF);
    checks++;
    if (outEnable !== 8'h0F || outPort !== 8'h0F) begin
      errors++;
      $display("FAIL mode_odr_outputs: outEnable=%h outPort=%h, expected 0f 0f", outEnable, outPort);
    end
    apb_read(5'h00, d);
    checks++;
    if (d !== 32'h0000_000F) begin
      errors++;
      $display("FAIL mode_upper_bits: PRDATA=%h, expected 0000000f", d);
    end
    apb_read(5'h04, d);
    checks++;
    if (d !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL odr_read: PRDATA=%h, expected 000000ff", d);
    end
    apb_write(5'h08, 32'h0000_0055);
    apb_read(5'h08, d);
    checks++;
    if (d !== 32'h0000_0030) begin
      errors++;
      $display("FAIL idr_ro_masked: PRDATA=%h, expected 00000030", d);
    end
    apb_write(5'h1C, 32'hFFFF_FFFF);
    apb_read(5'h1C, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reserved_read: PRDATA=%h, expected 00000000", d);
    end
    apb_write(5'h00, 32'h0);
    inPort = 8'h00;
    wait_cycles(4);
  endtask

  task automatic test_input_sync;
    logic [31:0] d;
    inPort = 8'hA5;
    apb_read(5'h08, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL idr_too_early: PRDATA=%h, expected 00000000", d);
    end
    inPort = 8'h00;
    wait_cycles(4);
    inPort = 8'hA5;
    wait_cycles(1);
    apb_read(5'h08, d);
    checks++;
    if (d !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL idr_latency: PRDATA=%h, expected 000000a5", d);
    end
    inPort = 8'h00;
    wait_cycles(4);
  endtask

  task automatic test_rise_irq;
    logic [31:0] d;
    apb_write(5'h10, 32'h01);
    apb_write(5'h0C, 32'h01);
    inPort = 8'h81;
    wait_cycles(2);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: irq=%b, expected 0", irq);
    end
    wait_cycles(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: irq=%b, expected 1", irq);
    end
    apb_read(5'h18, d);
    checks++;
    if (d !== 32'h01) begin
      errors++;
      $display("FAIL isr_rise: PRDATA=%h, expected 00000001", d);
    end
    apb_write(5'h18, 32'h01);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_w1c: irq=%b, expected 0", irq);
    end
    apb_read(5'h18, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL isr_w1c: PRDATA=%h, expected 00000000", d);
    end
  endtask

  task automatic test_w1c_race;
    logic [31:0] d;
    inPort = 8'h80;
    wait_cycles(4);
    inPort = 8'h81;
    wait_cycles(4);
    apb_read(5'h18, d);
    checks++;
    if (d !== 32'h01) begin
      errors++;
      $display("FAIL isr_rise_again: PRDATA=%h, expected 00000001", d);
    end
    inPort = 8'h80;
    wait_cycles(4);
    // New rise lands in ISR on the same edge as the W1C access.
    inPort = 8'h81;
    wait_cycles(1);
    apb_write(5'h18, 32'h01);
    apb_read(5'h18, d);
    checks++;
    if (d !== 32'h01 || irq !== 1'b1) begin
      errors++;
      $display("FAIL w1c_race: ISR=%h irq=%b, expected 00000001 1", d, irq);
    end
    apb_write(5'h18, 32'h01);
    apb_read(5'h18, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL w1c_after_race: PRDATA=%h, expected 00000000", d);
    end
  endtask

  task automatic test_fall_masked;
    logic [31:0] d;
    apb_write(5'h0C, 32'h00);
    apb_write(5'h10, 32'h00);
    apb_write(5'h14, 32'h02);
    inPort = 8'h83;
    wait_cycles(4);
    inPort = 8'h81;
    wait_cycles(4);
    apb_read(5'h18, d);
    checks++;
    if (d !== 32'h02 || irq !== 1'b0) begin
      errors++;
      $display("FAIL fall_masked: ISR=%h irq=%b, expected 00000002 0", d, irq);
    end
    apb_write(5'h0C, 32'h02);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL ier_enable_pending: irq=%b, expected 1", irq);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    apb_write(5'h00, 32'hFF);
    apb_write(5'h04, 32'hAA);
    apb_read(5'h04, d);
    checks++;
    if (outPort !== 8'hAA || d !== 32'hAA || irq !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: outPort=%h PRDATA=%h irq=%b, expected aa 000000aa 1", outPort, d, irq);
    end
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 5'h04; PWDATA = 32'h55; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 PRESET = 1'b1;
    #1;
    checks++;
    if ({PRDATA, PREADY, outPort, outEnable, irq} !== '0) begin
      errors++;
      $display("FAIL reset_mid: PRDATA=%h PREADY=%b outPort=%h outEnable=%h irq=%b, expected all 0",
               PRDATA, PREADY, outPort, outEnable, irq);
    end
    @(posedge PCLK); #1;
    checks++;
    if (PREADY !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_pready: PREADY=%b, expected 0", PREADY);
    end
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PRESET = 1'b0;
    apb_read(5'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL odr_after_reset: PRDATA=%h, expected 00000000", d);
    end
  endtask

  initial begin
    test_reset();
    test_mode_odr();
    test_input_sync();
    test_rise_irq();
    test_w1c_race();
    test_fall_masked();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
